// File: rtl/mf_disp_fb_ctrl_pkg.sv
// Shared configuration for the display frame-buffer write controller:
// parameter defaults and the fill-engine state encoding.
package mf_disp_fb_ctrl_pkg;

    localparam int unsigned FB_WORDS_DEF = 16384;
    localparam int unsigned ADDR_W_DEF   = 16;

    typedef enum logic {
        FBC_IDLE = 1'b0,
        FBC_FILL = 1'b1
    } fbc_state_t;

endpackage

// File: rtl/mf_disp_fb_fill.sv
// Back-buffer fill engine: walks word indices 0..FB_WORDS-1 writing a latched
// fill word, advancing only on cycles where the arbiter does not stall it.
module mf_disp_fb_fill
    import mf_disp_fb_ctrl_pkg::*;
#(
    parameter int unsigned FB_WORDS = FB_WORDS_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       start_data,
    input  logic              stall,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data,
    output logic              last
);

    localparam int unsigned     CNT_W    = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FB_WORDS - 1);

    fbc_state_t       state;
    fbc_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      word;
    logic             issue;

    assign req   = (state == FBC_FILL);
    assign last  = req && (cnt == CNT_LAST);
    assign issue = req && !stall;
    assign addr  = ADDR_W'({cnt, 2'b00});
    assign data  = word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FBC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start is only honoured from IDLE, so a restart mid-fill neither
    // rewinds the counter nor replaces the fill word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            word <= '0;
        end else if (state == FBC_IDLE && start) begin
            cnt  <= '0;
            word <= start_data;
        end else if (issue) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FBC_IDLE: if (start)          state_nxt = FBC_FILL;
            FBC_FILL: if (issue && last)  state_nxt = FBC_IDLE;
            default:                      state_nxt = FBC_IDLE;
        endcase
    end

endmodule

// File: rtl/mf_disp_fb_ctrl.sv
// Frame-buffer write-side controller: arbitrates CPU and fill writes onto a
// single registered write port and performs buffer swaps only at vsync.
module mf_disp_fb_ctrl
    import mf_disp_fb_ctrl_pkg::*;
#(
    parameter int unsigned FB_WORDS = FB_WORDS_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cpu_fb_req,
    input  logic [ADDR_W-1:0] cpu_fb_addr,
    input  logic [31:0]       cpu_fb_data,
    output logic              cpu_fb_gnt,
    input  logic              fill_start,
    input  logic [31:0]       fill_data,
    output logic              fill_busy,
    input  logic              swap_req,
    input  logic              vsync_pulse,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              fb_active_sel,
    output logic              fb_wr_vld,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [31:0]       fb_wr_data
);

    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic [31:0]       fill_word;
    logic              fill_last;
    logic              fill_stall;
    logic              fill_issue;
    logic              swap_exec;

    // The swap cycle owns the port: neither requester writes alongside the select change
    assign swap_exec  = vsync_pulse && swap_pending && !fill_req;
    assign cpu_fb_gnt = cpu_fb_req && !swap_exec;
    assign fill_stall = swap_exec || cpu_fb_req;
    assign fill_issue = fill_req && !fill_stall;
    assign fill_busy  = fill_req;

    mf_disp_fb_fill #(
        .FB_WORDS (FB_WORDS),
        .ADDR_W   (ADDR_W)
    ) u_fill (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .start      (fill_start),
        .start_data (fill_data),
        .stall      (fill_stall),
        .req        (fill_req),
        .addr       (fill_addr),
        .data       (fill_word),
        .last       (fill_last)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            swap_pending  <= 1'b0;
            swap_done     <= 1'b0;
            fb_active_sel <= 1'b0;
            fb_wr_vld     <= 1'b0;
            fb_wr_addr    <= '0;
            fb_wr_data    <= '0;
        end else begin
            swap_pending  <= swap_exec ? 1'b0 : (swap_pending || swap_req);
            swap_done     <= swap_exec;
            fb_active_sel <= fb_active_sel ^ swap_exec;
            fb_wr_vld     <= cpu_fb_gnt || fill_issue;
            if (cpu_fb_gnt) begin
                fb_wr_addr <= cpu_fb_addr & ~ADDR_W'(3);
                fb_wr_data <= cpu_fb_data;
            end else if (fill_issue) begin
                fb_wr_addr <= fill_addr;
                fb_wr_data <= fill_word;
            end
        end
    end

    logic unused_last;
    assign unused_last = fill_last;

endmodule

// File: tb/tb_mf_disp_fb_ctrl.sv
// Directed bench for mf_disp_fb_ctrl with a 16-word buffer: reset, CPU write,
// fill with and without CPU interference, swap timing, reset mid-operation.
module tb_mf_disp_fb_ctrl;

    localparam int unsigned FBW = 16;
    localparam int unsigned AW  = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          cpu_fb_req;
    logic [AW-1:0] cpu_fb_addr;
    logic [31:0]   cpu_fb_data;
    logic          cpu_fb_gnt;
    logic          fill_start;
    logic [31:0]   fill_data;
    logic          fill_busy;
    logic          swap_req;
    logic          vsync_pulse;
    logic          swap_pending;
    logic          swap_done;
    logic          fb_active_sel;
    logic          fb_wr_vld;
    logic [AW-1:0] fb_wr_addr;
    logic [31:0]   fb_wr_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mf_disp_fb_ctrl #(
        .FB_WORDS (FBW),
        .ADDR_W   (AW)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .cpu_fb_req    (cpu_fb_req),
        .cpu_fb_addr   (cpu_fb_addr),
        .cpu_fb_data   (cpu_fb_data),
        .cpu_fb_gnt    (cpu_fb_gnt),
        .fill_start    (fill_start),
        .fill_data     (fill_data),
        .fill_busy     (fill_busy),
        .swap_req      (swap_req),
        .vsync_pulse   (vsync_pulse),
        .swap_pending  (swap_pending),
        .swap_done     (swap_done),
        .fb_active_sel (fb_active_sel),
        .fb_wr_vld     (fb_wr_vld),
        .fb_wr_addr    (fb_wr_addr),
        .fb_wr_data    (fb_wr_data)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    logic [AW-1:0] rec_addr[$];
    logic [31:0]   rec_data[$];

    initial begin
        int unsigned busy_cnt;
        int unsigned nw;
        int unsigned nfill;
        int unsigned cpu_cyc;
        bit          cpu_started;
        logic [AW-1:0] ea;
        logic [31:0]   ed;

        sys_rst_n   = 1'b0;
        cpu_fb_req  = 1'b0;
        cpu_fb_addr = '0;
        cpu_fb_data = '0;
        fill_start  = 1'b0;
        fill_data   = '0;
        swap_req    = 1'b0;
        vsync_pulse = 1'b0;

        // reset
        tick();
        tick();
        chk("rst_vld",     32'(fb_wr_vld), 32'd0);
        chk("rst_addr",    32'(fb_wr_addr), 32'd0);
        chk("rst_data",    fb_wr_data, 32'd0);
        chk("rst_sel",     32'(fb_active_sel), 32'd0);
        chk("rst_busy",    32'(fill_busy), 32'd0);
        chk("rst_pending", 32'(swap_pending), 32'd0);
        chk("rst_done",    32'(swap_done), 32'd0);
        chk("rst_gnt",     32'(cpu_fb_gnt), 32'd0);
        sys_rst_n = 1'b1;
        tick();
        tick();
        chk("idle_vld", 32'(fb_wr_vld), 32'd0);

        // single CPU write; low address bits are masked
        cpu_fb_req  = 1'b1;
        cpu_fb_addr = 16'h0104;
        cpu_fb_data = 32'hDEADBEEF;
        #1;
        chk("cpu_gnt", 32'(cpu_fb_gnt), 32'd1);
        tick();
        cpu_fb_req = 1'b0;
        chk("cpu_vld",  32'(fb_wr_vld), 32'd1);
        chk("cpu_addr", 32'(fb_wr_addr), 32'h0104);
        chk("cpu_data", fb_wr_data, 32'hDEADBEEF);
        cpu_fb_req  = 1'b1;
        cpu_fb_addr = 16'h0107;
        cpu_fb_data = 32'h0BADF00D;
        tick();
        cpu_fb_req = 1'b0;
        chk("cpu_addr_mask", 32'(fb_wr_addr), 32'h0104);
        chk("cpu_data2",     fb_wr_data, 32'h0BADF00D);
        tick();
        chk("cpu_vld_drop", 32'(fb_wr_vld), 32'd0);

        // plain fill of 16 words
        fill_start = 1'b1;
        fill_data  = 32'h00000000;
        tick();
        fill_start = 1'b0;
        busy_cnt = 0;
        nw = 0;
        for (int c = 0; c < 30; c++) begin
            if (fill_busy) busy_cnt++;
            if (fb_wr_vld) begin
                chk("fill_addr", 32'(fb_wr_addr), nw * 4);
                chk("fill_data", fb_wr_data, 32'h0);
                nw++;
            end
            tick();
        end
        chk("fill_writes", nw, 32'd16);
        chk("fill_busy_cycles", busy_cnt, 32'd16);

        // fill interrupted by 3 CPU writes after the 5th fill write
        fill_start = 1'b1;
        fill_data  = 32'hA5A55A5A;
        tick();
        fill_start = 1'b0;
        busy_cnt = 0;
        nfill = 0;
        cpu_cyc = 0;
        cpu_started = 1'b0;
        rec_addr.delete();
        rec_data.delete();
        for (int c = 0; c < 40; c++) begin
            if (fill_busy) busy_cnt++;
            if (fb_wr_vld) begin
                rec_addr.push_back(fb_wr_addr);
                rec_data.push_back(fb_wr_data);
                if (fb_wr_data == 32'hA5A55A5A) nfill++;
            end
            if (!cpu_started && nfill == 5) cpu_started = 1'b1;
            if (cpu_started && cpu_cyc < 3) begin
                cpu_fb_req  = 1'b1;
                cpu_fb_addr = 16'(16'h0200 + 4 * cpu_cyc);
                cpu_fb_data = 32'h10000000 + cpu_cyc;
                #1;
                chk("mix_gnt", 32'(cpu_fb_gnt), 32'd1);
                cpu_cyc++;
            end else begin
                cpu_fb_req = 1'b0;
            end
            tick();
        end
        cpu_fb_req = 1'b0;
        chk("mix_writes", rec_addr.size(), 32'd19);
        chk("mix_busy_cycles", busy_cnt, 32'd19);
        for (int k = 0; k < 19 && k < rec_addr.size(); k++) begin
            if (k < 5) begin
                ea = 16'(4 * k);
                ed = 32'hA5A55A5A;
            end else if (k < 8) begin
                ea = 16'(16'h0200 + 4 * (k - 5));
                ed = 32'h10000000 + 32'(k - 5);
            end else begin
                ea = 16'(4 * (k - 3));
                ed = 32'hA5A55A5A;
            end
            chk("mix_addr", 32'(rec_addr[k]), 32'(ea));
            chk("mix_data", rec_data[k], ed);
        end

        // swap with a competing CPU request on the vsync cycle
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swp_pending", 32'(swap_pending), 32'd1);
        chk("swp_sel_hold", 32'(fb_active_sel), 32'd0);
        for (int c = 0; c < 9; c++) tick();
        vsync_pulse = 1'b1;
        cpu_fb_req  = 1'b1;
        cpu_fb_addr = 16'h0040;
        cpu_fb_data = 32'h12345678;
        #1;
        chk("swp_gnt_blocked", 32'(cpu_fb_gnt), 32'd0);
        tick();
        vsync_pulse = 1'b0;
        chk("swp_done", 32'(swap_done), 32'd1);
        chk("swp_sel", 32'(fb_active_sel), 32'd1);
        chk("swp_pending_clr", 32'(swap_pending), 32'd0);
        chk("swp_no_write", 32'(fb_wr_vld), 32'd0);
        chk("swp_gnt_after", 32'(cpu_fb_gnt), 32'd1);
        tick();
        cpu_fb_req = 1'b0;
        chk("swp_cpu_vld", 32'(fb_wr_vld), 32'd1);
        chk("swp_cpu_addr", 32'(fb_wr_addr), 32'h0040);
        chk("swp_done_pulse", 32'(swap_done), 32'd0);

        // swap_req coincident with vsync waits for the next vsync
        swap_req    = 1'b1;
        vsync_pulse = 1'b1;
        tick();
        swap_req    = 1'b0;
        vsync_pulse = 1'b0;
        chk("same_pending", 32'(swap_pending), 32'd1);
        chk("same_sel", 32'(fb_active_sel), 32'd1);
        chk("same_done", 32'(swap_done), 32'd0);
        tick();
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        chk("same_done2", 32'(swap_done), 32'd1);
        chk("same_sel2", 32'(fb_active_sel), 32'd0);

        // swap deferred past a fill; restart mid-fill ignored
        fill_start = 1'b1;
        fill_data  = 32'h11111111;
        tick();
        fill_start = 1'b0;
        busy_cnt = 0;
        nw = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 7) begin
                chk("def_pending", 32'(swap_pending), 32'd1);
                chk("def_done", 32'(swap_done), 32'd0);
                chk("def_sel", 32'(fb_active_sel), 32'd0);
            end
            if (fill_busy) busy_cnt++;
            if (fb_wr_vld) begin
                chk("def_fill_addr", 32'(fb_wr_addr), nw * 4);
                chk("def_fill_data", fb_wr_data, 32'h11111111);
                nw++;
            end
            swap_req    = (c == 3);
            vsync_pulse = (c == 6);
            fill_start  = (c == 6);
            fill_data   = (c == 6) ? 32'hFFFFFFFF : 32'h0;
            tick();
        end
        chk("def_writes", nw, 32'd16);
        chk("def_busy_cycles", busy_cnt, 32'd16);
        chk("def_pending_after", 32'(swap_pending), 32'd1);
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        chk("def_done2", 32'(swap_done), 32'd1);
        chk("def_sel2", 32'(fb_active_sel), 32'd1);
        chk("def_pending_clr", 32'(swap_pending), 32'd0);

        // reset with a fill running and a swap pending
        swap_req = 1'b1;
        fill_start = 1'b1;
        fill_data  = 32'h22222222;
        tick();
        swap_req = 1'b0;
        fill_start = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b0;
        tick();
        chk("mrst_busy", 32'(fill_busy), 32'd0);
        chk("mrst_sel", 32'(fb_active_sel), 32'd0);
        chk("mrst_pending", 32'(swap_pending), 32'd0);
        chk("mrst_vld", 32'(fb_wr_vld), 32'd0);
        sys_rst_n = 1'b1;
        tick();
        tick();
        chk("mrst_no_write", 32'(fb_wr_vld), 32'd0);
        chk("mrst_busy2", 32'(fill_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
